// File: rtl/s2_frame_rx.sv
// Serial frame receiver for the S1->S2 upload link: deserializes sen/sd frames
// (address then data, MSB first) and writes each good frame into RB2.
module s2_frame_rx #(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned NUM_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sen,
  input  logic              sd,
  output logic              RB_RW,
  output logic [ADDR_W-1:0] RB_A,
  output logic [DATA_W-1:0] RB_D,
  output logic              done,
  output logic              err
);

  localparam int unsigned FW     = ADDR_W + DATA_W;
  localparam int unsigned BCNT_W = $clog2(FW + 1);
  localparam int unsigned FCNT_W = $clog2(NUM_FRAMES + 1);

  localparam logic [BCNT_W-1:0] LAST_BIT   = BCNT_W'(FW - 1);
  localparam logic [FCNT_W-1:0] FRAMES_MAX = FCNT_W'(NUM_FRAMES);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WRITE,
    HOLD,
    DONE
  } state_e;

  state_e              state_q, state_nx;
  logic [FW-2:0]       shreg_q, shreg_nx;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_nx;
  logic [FCNT_W-1:0]   frm_cnt_q, frm_cnt_nx;
  logic                rb_rw_nx;
  logic [ADDR_W-1:0]   rb_a_nx;
  logic [DATA_W-1:0]   rb_d_nx;
  logic                done_nx;
  logic                err_nx;

  logic [FW-1:0]       frame_c;
  logic                bit_take_c;
  logic                last_bit_c;
  logic [FCNT_W-1:0]   frm_inc_c;

  // The incoming bit completes the frame, so the write fields come straight off the shifter.
  assign frame_c    = {shreg_q, sd};
  assign bit_take_c = en & ~sen;
  assign last_bit_c = (bit_cnt_q == LAST_BIT);
  assign frm_inc_c  = frm_cnt_q + FCNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: begin
        if (bit_take_c) state_nx = SHIFT;
      end
      SHIFT: begin
        if (!en || sen)      state_nx = IDLE;
        else if (last_bit_c) state_nx = WRITE;
      end
      WRITE: begin
        // en is deliberately ignored here: the write has already been issued.
        if (!sen)                         state_nx = HOLD;
        else if (frm_inc_c == FRAMES_MAX) state_nx = DONE;
        else                              state_nx = IDLE;
      end
      HOLD: begin
        if (!en || sen) state_nx = (frm_cnt_q == FRAMES_MAX) ? DONE : IDLE;
      end
      DONE: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    shreg_nx   = shreg_q;
    bit_cnt_nx = bit_cnt_q;
    frm_cnt_nx = frm_cnt_q;
    rb_rw_nx   = 1'b1;
    rb_a_nx    = RB_A;
    rb_d_nx    = RB_D;
    err_nx     = err;
    done_nx    = done | (state_nx == DONE);
    case (state_q)
      IDLE: begin
        if (bit_take_c) begin
          shreg_nx   = frame_c[FW-2:0];
          bit_cnt_nx = BCNT_W'(1);
        end
      end
      SHIFT: begin
        if (bit_take_c) begin
          shreg_nx   = frame_c[FW-2:0];
          bit_cnt_nx = bit_cnt_q + BCNT_W'(1);
          if (last_bit_c) begin
            rb_rw_nx = 1'b0;
            rb_a_nx  = frame_c[FW-1:DATA_W];
            rb_d_nx  = frame_c[DATA_W-1:0];
          end
        end else if (en && sen) begin
          err_nx = 1'b1;
        end
      end
      WRITE: begin
        frm_cnt_nx = frm_inc_c;
        if (!sen) err_nx = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      frm_cnt_q <= '0;
      RB_RW     <= 1'b1;
      RB_A      <= '0;
      RB_D      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      shreg_q   <= shreg_nx;
      bit_cnt_q <= bit_cnt_nx;
      frm_cnt_q <= frm_cnt_nx;
      RB_RW     <= rb_rw_nx;
      RB_A      <= rb_a_nx;
      RB_D      <= rb_d_nx;
      done      <= done_nx;
      err       <= err_nx;
    end
  end

endmodule

// File: tb/tb_s2_frame_rx.sv
// Bench for s2_frame_rx: random frames against a frame-level model of the link
// (one write per run of >= FW low sen bits, done after NUM_FRAMES writes).
module tb_s2_frame_rx;

  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned DATA_W     = 18;
  localparam int unsigned NUM_FRAMES = 8;
  localparam int unsigned FW         = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst, en, sen, sd;
  logic              RB_RW;
  logic [ADDR_W-1:0] RB_A;
  logic [DATA_W-1:0] RB_D;
  logic              done, err;

  typedef struct packed {
    int unsigned       cyc;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         act_q[$];
  int          n_run = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned done_rise = 0;
  int unsigned long_pulse = 0;
  logic        rw_prev = 1'b1;
  logic        done_prev = 1'b0;
  int          model_cnt;
  logic        model_err;
  logic        model_done;

  s2_frame_rx #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_FRAMES(NUM_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sen(sen), .sd(sd),
    .RB_RW(RB_RW), .RB_A(RB_A), .RB_D(RB_D), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write cycle and the cycle done rises.
  always @(negedge clk) begin
    if (RB_RW === 1'b0) begin
      act_q.push_back(wr_t'{cyc: cyc, a: RB_A, d: RB_D});
      if (rw_prev === 1'b0) long_pulse <= long_pulse + 1;
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise <= cyc;
    rw_prev   <= RB_RW;
    done_prev <= done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; sen = 1'b1; sd = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_cnt = 0; model_err = 1'b0; model_done = 1'b0;
    exp_q.delete();
    act_q.delete();
  endtask

  function automatic logic [FW-1:0] rand_frame();
    rand_frame = FW'($urandom);
  endfunction

  // Drive nbits low-sen bits (frame bits first, random filler past FW) then gap idle cycles.
  task automatic send_bits(input logic [FW-1:0] f, input int nbits, input int gap);
    logic take;
    take = en && !model_done;
    for (int i = 0; i < nbits; i++) begin
      sen = 1'b0;
      sd  = (i < int'(FW)) ? f[FW-1-i] : 1'($urandom);
      tick();
      if (i == int'(FW) - 1 && take) begin
        model_cnt++;
        exp_q.push_back(wr_t'{cyc: cyc, a: f[FW-1:DATA_W], d: f[DATA_W-1:0]});
      end
    end
    if (take && nbits != int'(FW)) model_err = 1'b1;
    if (model_cnt >= int'(NUM_FRAMES)) model_done = 1'b1;
    sen = 1'b1; sd = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_run++; if (RB_RW !== 1'b1) begin n_fail++; $display("FAIL reset RB_RW: got %b expected 1", RB_RW); end
    n_run++; if (RB_A !== '0) begin n_fail++; $display("FAIL reset RB_A: got %h expected 0", RB_A); end
    n_run++; if (RB_D !== '0) begin n_fail++; $display("FAIL reset RB_D: got %h expected 0", RB_D); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
    n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b expected 0", err); end
  endtask

  task automatic test_eight_frames();
    do_reset();
    for (int n = 0; n < 8; n++)
      send_bits({ADDR_W'(n), 18'h2A5C3 ^ DATA_W'(n)}, FW, 1);
    tick(); tick();
    n_run++; if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL eight count: got %0d expected %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_run++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL eight write[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                 i, act_q[i].cyc, act_q[i].a, act_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
      end
    end
    if (exp_q.size() == 8) begin
      n_run++; if (done_rise !== exp_q[7].cyc + 1) begin n_fail++; $display("FAIL eight done_cycle: got %0d expected %0d", done_rise, exp_q[7].cyc + 1); end
    end
    n_run++; if (done !== 1'b1) begin n_fail++; $display("FAIL eight done: got %b expected 1", done); end
    n_run++; if (err !== model_err) begin n_fail++; $display("FAIL eight err: got %b expected %b", err, model_err); end
  endtask

  task automatic test_overwrite();
    do_reset();
    send_bits({3'b101, 18'h3FFFF}, FW, 5);
    send_bits({3'b101, 18'h00001}, FW, 1);
    tick();
    n_run++; if (act_q.size() !== 2) begin n_fail++; $display("FAIL overwrite count: got %0d expected 2", act_q.size()); end
    if (act_q.size() >= 2) begin
      n_run++;
      if (act_q[1].a !== 3'b101 || act_q[1].d !== 18'h00001) begin
        n_fail++; $display("FAIL overwrite last: got a=%h d=%h expected a=5 d=00001", act_q[1].a, act_q[1].d);
      end
    end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL overwrite early_done: got %b expected 0", done); end
    for (int n = 0; n < 6; n++) send_bits(rand_frame(), FW, $urandom_range(1, 3));
    tick(); tick();
    n_run++; if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL overwrite total: got %0d expected %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_run++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL overwrite write[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                 i, act_q[i].cyc, act_q[i].a, act_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
      end
    end
    if (exp_q.size() == 8) begin
      n_run++; if (done_rise !== exp_q[7].cyc + 1) begin n_fail++; $display("FAIL overwrite done_cycle: got %0d expected %0d", done_rise, exp_q[7].cyc + 1); end
    end
  endtask

  task automatic test_short();
    do_reset();
    send_bits(rand_frame(), 12, 2);
    n_run++; if (err !== 1'b1) begin n_fail++; $display("FAIL short err: got %b expected 1", err); end
    n_run++; if (act_q.size() !== 0) begin n_fail++; $display("FAIL short nowrite: got %0d writes expected 0", act_q.size()); end
    for (int k = 0; k < 3; k++) begin
      send_bits(rand_frame(), FW, 1);
      send_bits(rand_frame(), $urandom_range(1, FW - 1), $urandom_range(1, 3));
    end
    send_bits(rand_frame(), FW, 2);
    n_run++; if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL short count: got %0d expected %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_run++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL short write[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                 i, act_q[i].cyc, act_q[i].a, act_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
      end
    end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL short done: got %b expected 0", done); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_bits(rand_frame(), FW + 2, 1);
    n_run++; if (err !== 1'b1) begin n_fail++; $display("FAIL overrun err: got %b expected 1", err); end
    for (int n = 0; n < 7; n++) send_bits(rand_frame(), FW, 1);
    tick(); tick();
    n_run++; if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL overrun count: got %0d expected %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_run++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL overrun write[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                 i, act_q[i].cyc, act_q[i].a, act_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
      end
    end
    n_run++; if (done !== model_done) begin n_fail++; $display("FAIL overrun done: got %b expected %b", done, model_done); end
  endtask

  task automatic test_rst_mid();
    logic [FW-1:0] f;
    do_reset();
    send_bits(rand_frame(), 7, 2);
    send_bits(rand_frame(), FW, 2);
    n_run++; if (act_q.size() !== 1) begin n_fail++; $display("FAIL rstmid setup: got %0d writes expected 1", act_q.size()); end
    n_run++; if (err !== 1'b1) begin n_fail++; $display("FAIL rstmid setup_err: got %b expected 1", err); end
    act_q.delete();
    send_bits(rand_frame(), 10, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_run++; if (act_q.size() !== 0) begin n_fail++; $display("FAIL rstmid nowrite: got %0d writes expected 0", act_q.size()); end
    n_run++;
    if (RB_RW !== 1'b1 || RB_A !== '0 || RB_D !== '0 || err !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid outputs: got rw=%b a=%h d=%h err=%b done=%b expected 1 0 0 0 0", RB_RW, RB_A, RB_D, err, done);
    end
    model_cnt = 0; model_err = 1'b0; model_done = 1'b0;
    exp_q.delete();
    f = rand_frame();
    send_bits(f, FW, 2);
    n_run++;
    if (act_q.size() !== 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL rstmid next_count: got %0d expected 1", act_q.size());
    end else if (act_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL rstmid next: got a=%h d=%h expected a=%h d=%h", act_q[0].a, act_q[0].d, f[FW-1:DATA_W], f[DATA_W-1:0]);
    end
    n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid err: got %b expected 0", err); end
  endtask

  task automatic test_enable();
    logic [FW-1:0] f;
    do_reset();
    en = 1'b0;
    for (int n = 0; n < 3; n++) send_bits(rand_frame(), FW, 1);
    en = 1'b1;
    n_run++; if (act_q.size() !== 0) begin n_fail++; $display("FAIL enable off_writes: got %0d expected 0", act_q.size()); end
    f = rand_frame();
    for (int i = 0; i < int'(FW); i++) begin
      if (i == 10) en = 1'b0;
      sen = 1'b0; sd = f[FW-1-i];
      tick();
    end
    sen = 1'b1; tick(); en = 1'b1; tick();
    n_run++; if (act_q.size() !== 0) begin n_fail++; $display("FAIL enable abort_writes: got %0d expected 0", act_q.size()); end
    n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL enable err: got %b expected 0", err); end
    send_bits(rand_frame(), FW, 2);
    n_run++;
    if (act_q.size() !== 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL enable resume_count: got %0d expected 1", act_q.size());
    end else if (act_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL enable resume: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                         act_q[0].cyc, act_q[0].a, act_q[0].d, exp_q[0].cyc, exp_q[0].a, exp_q[0].d);
    end
  endtask

  task automatic test_after_done();
    do_reset();
    for (int n = 0; n < 8; n++) send_bits(rand_frame(), FW, $urandom_range(1, 2));
    tick();
    n_run++; if (done !== 1'b1) begin n_fail++; $display("FAIL afterdone done: got %b expected 1", done); end
    send_bits(rand_frame(), FW, 1);
    send_bits(rand_frame(), 9, 2);
    n_run++; if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL afterdone count: got %0d expected %0d", act_q.size(), exp_q.size()); end
    n_run++; if (done !== 1'b1) begin n_fail++; $display("FAIL afterdone sticky: got %b expected 1", done); end
    n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL afterdone err: got %b expected 0", err); end
  endtask

  initial begin
    test_reset();
    test_eight_frames();
    test_overwrite();
    test_short();
    test_overrun();
    test_rst_mid();
    test_enable();
    test_after_done();
    n_run++; if (long_pulse !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d multi-cycle writes expected 0", long_pulse); end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
